// File: rtl/io_stream_loader.sv
// Host-side stream loader: assembles narrow input beats into config, instruction and
// data memory words, starts the core, then streams the output region back per frame.
module io_stream_loader #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned FRAME_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [ADDR_WIDTH-1:0]  instr_max_wadr,
    output logic [ADDR_WIDTH-1:0]  input_max_wadr,
    output logic [ADDR_WIDTH-1:0]  input_wadr_offset,
    output logic [ADDR_WIDTH-1:0]  output_max_adr,
    output logic [ADDR_WIDTH-1:0]  output_adr_offset,
    output logic                   cfg_done,
    output logic                   mem_wen,
    output logic                   mem_wsel,
    output logic [ADDR_WIDTH-1:0]  mem_wadr,
    output logic [WORD_WIDTH-1:0]  mem_wdata,
    output logic                   start,
    input  logic                   done,
    output logic                   mem_ren,
    output logic [ADDR_WIDTH-1:0]  mem_radr,
    input  logic [WORD_WIDTH-1:0]  mem_rdata,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [FRAME_WIDTH-1:0] frame_cnt
);

    localparam int unsigned BEATS   = WORD_WIDTH / IN_WIDTH;
    localparam int unsigned CHUNKS  = WORD_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_CFG   = 3'd0,
        S_INSTR = 3'd1,
        S_DATA  = 3'd2,
        S_RUN   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                state;
    logic [2:0]            cfg_idx;
    logic [BEAT_W-1:0]     beat_idx;
    logic [WORD_WIDTH-1:0] asm_word;
    logic [WORD_WIDTH-1:0] asm_next;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] wcnt_inc;
    logic                  last_wr;
    logic                  rd_vld;
    logic [CHUNK_W-1:0]    chunk;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] shifted;
    logic                  accept;

    assign accept   = in_vld && in_rdy;
    assign wcnt_inc = wcnt + ADDR_WIDTH'(1);
    assign shifted  = shreg >> OUT_WIDTH;

    // Drop the current beat into its slot of the word under assembly.
    always_comb begin
        asm_next = asm_word;
        asm_next[int'(beat_idx) * int'(IN_WIDTH) +: IN_WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_CFG;
            cfg_idx           <= '0;
            beat_idx          <= '0;
            asm_word          <= '0;
            wcnt              <= '0;
            last_wr           <= 1'b0;
            rd_vld            <= 1'b0;
            chunk             <= '0;
            shreg             <= '0;
            in_rdy            <= 1'b1;
            instr_max_wadr    <= '0;
            input_max_wadr    <= '0;
            input_wadr_offset <= '0;
            output_max_adr    <= '0;
            output_adr_offset <= '0;
            cfg_done          <= 1'b0;
            mem_wen           <= 1'b0;
            mem_wsel          <= 1'b0;
            mem_wadr          <= '0;
            mem_wdata         <= '0;
            start             <= 1'b0;
            mem_ren           <= 1'b0;
            mem_radr          <= '0;
            out_data          <= '0;
            out_vld           <= 1'b0;
            frame_cnt         <= '0;
        end else begin
            mem_wen <= 1'b0;
            start   <= 1'b0;
            mem_ren <= 1'b0;
            rd_vld  <= mem_ren;

            case (state)
                S_CFG: begin
                    if (accept) begin
                        case (cfg_idx)
                            3'd0:    instr_max_wadr    <= in_data[ADDR_WIDTH-1:0];
                            3'd1:    input_max_wadr    <= in_data[ADDR_WIDTH-1:0];
                            3'd2:    input_wadr_offset <= in_data[ADDR_WIDTH-1:0];
                            3'd3:    output_max_adr    <= in_data[ADDR_WIDTH-1:0];
                            default: output_adr_offset <= in_data[ADDR_WIDTH-1:0];
                        endcase
                        if (cfg_idx == 3'd4) begin
                            cfg_idx  <= '0;
                            cfg_done <= 1'b1;
                            state    <= S_INSTR;
                        end else begin
                            cfg_idx <= cfg_idx + 3'd1;
                        end
                    end
                end

                S_INSTR, S_DATA: begin
                    if (last_wr) begin
                        // Final data word was strobed last cycle; kick the core now.
                        last_wr <= 1'b0;
                        start   <= 1'b1;
                        state   <= S_RUN;
                    end else if (accept) begin
                        if (beat_idx == BEAT_W'(BEATS - 1)) begin
                            beat_idx  <= '0;
                            asm_word  <= '0;
                            mem_wen   <= 1'b1;
                            mem_wdata <= asm_next;
                            if (state == S_INSTR) begin
                                mem_wsel <= 1'b0;
                                mem_wadr <= wcnt;
                                if (wcnt == instr_max_wadr) begin
                                    wcnt  <= '0;
                                    state <= S_DATA;
                                end else begin
                                    wcnt <= wcnt_inc;
                                end
                            end else begin
                                mem_wsel <= 1'b1;
                                mem_wadr <= input_wadr_offset + wcnt;
                                if (wcnt == input_max_wadr) begin
                                    wcnt    <= '0;
                                    in_rdy  <= 1'b0;
                                    last_wr <= 1'b1;
                                end else begin
                                    wcnt <= wcnt_inc;
                                end
                            end
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                            asm_word <= asm_next;
                        end
                    end
                end

                S_RUN: begin
                    if (done) begin
                        state    <= S_OUT;
                        wcnt     <= '0;
                        mem_ren  <= 1'b1;
                        mem_radr <= output_adr_offset;
                    end
                end

                S_OUT: begin
                    if (rd_vld) begin
                        shreg    <= mem_rdata;
                        out_data <= mem_rdata[OUT_WIDTH-1:0];
                        out_vld  <= 1'b1;
                        chunk    <= '0;
                    end else if (out_vld && out_rdy) begin
                        if (chunk == CHUNK_W'(CHUNKS - 1)) begin
                            out_vld <= 1'b0;
                            if (wcnt == output_max_adr) begin
                                wcnt      <= '0;
                                frame_cnt <= frame_cnt + FRAME_WIDTH'(1);
                                in_rdy    <= 1'b1;
                                state     <= S_DATA;
                            end else begin
                                wcnt     <= wcnt_inc;
                                mem_ren  <= 1'b1;
                                mem_radr <= output_adr_offset + wcnt_inc;
                            end
                        end else begin
                            shreg    <= shifted;
                            out_data <= shifted[OUT_WIDTH-1:0];
                            chunk    <= chunk + CHUNK_W'(1);
                        end
                    end
                end

                default: begin
                    state  <= S_CFG;
                    in_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule
